// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-128 key schedule sequencer.
// Drives round_key_gen through one full expansion, keeps every round key in an
// internal store and then replays the schedule per data block, ascending for
// the cipher core or descending for the decipher core.
module key_sched_ctrl #(
  parameter int KEY_W  = 128,
  parameter int ROUNDS = 10,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in_valid,
  input  logic [KEY_W-1:0] key_in,
  output logic             key_in_ready,
  output logic             gen_dv,
  output logic [KEY_W-1:0] gen_cipher_key,
  output logic             gen_key_needed,
  input  logic [IDX_W-1:0] gen_rcon_addr,
  output logic [7:0]       gen_next_rcon,
  input  logic [KEY_W-1:0] gen_rkey,
  input  logic             gen_key_ready,
  input  logic             blk_start,
  input  logic             blk_dir,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [KEY_W-1:0] rk_data,
  output logic [IDX_W-1:0] rk_round,
  output logic             keys_valid,
  output logic             blk_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_CAPT,
    S_READY,
    S_SERVE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] wr_idx_reg;
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  logic             dir_reg;
  logic             gkr_d_reg;

  // Round-key store, one entry per round, filled once per key load.
  logic [KEY_W-1:0] store [0:ROUNDS];

  logic key_acc;
  logic cap;
  logic wr_last;
  logic blk_acc;
  logic rk_acc;
  logic rd_last;

  // key_in_ready is only ever high in IDLE/READY, so it alone qualifies a load.
  assign key_acc = key_in_valid & key_in_ready;
  // Capture only on a fresh rising edge so a held-high ready is not re-captured.
  assign cap     = (state_reg == S_CAPT) & gen_key_ready & ~gkr_d_reg;
  assign wr_last = (wr_idx_reg == LAST_IDX);
  // A pending key load beats a pending block request.
  assign blk_acc = (state_reg == S_READY) & blk_start & ~key_acc;
  assign rk_acc  = rk_valid & rk_ready;
  assign rd_last = dir_reg ? (rd_idx_reg == '0) : (rd_idx_reg == LAST_IDX);

  // RCON ROM, looked up directly from the generator's round counter.
  always_comb begin
    gen_next_rcon = 8'h00;
    case (gen_rcon_addr)
      IDX_W'(0): gen_next_rcon = 8'h01;
      IDX_W'(1): gen_next_rcon = 8'h02;
      IDX_W'(2): gen_next_rcon = 8'h04;
      IDX_W'(3): gen_next_rcon = 8'h08;
      IDX_W'(4): gen_next_rcon = 8'h10;
      IDX_W'(5): gen_next_rcon = 8'h20;
      IDX_W'(6): gen_next_rcon = 8'h40;
      IDX_W'(7): gen_next_rcon = 8'h80;
      IDX_W'(8): gen_next_rcon = 8'h1b;
      IDX_W'(9): gen_next_rcon = 8'h36;
      default:   gen_next_rcon = 8'h00;
    endcase
  end

  // Next-state and read-index selection.
  always_comb begin
    state_next  = state_reg;
    rd_idx_next = rd_idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (key_acc) state_next = S_START;
      end
      S_START: begin
        state_next = S_CAPT;
      end
      S_CAPT: begin
        if (cap && wr_last) state_next = S_READY;
      end
      S_READY: begin
        if (key_acc) begin
          state_next = S_START;
        end else if (blk_acc) begin
          state_next  = S_SERVE;
          rd_idx_next = blk_dir ? LAST_IDX : '0;
        end
      end
      S_SERVE: begin
        if (rk_acc) begin
          if (rd_last) begin
            state_next = S_READY;
          end else begin
            rd_idx_next = dir_reg ? (rd_idx_reg - ONE_IDX) : (rd_idx_reg + ONE_IDX);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Control state and registered handshake/pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      key_in_ready   <= 1'b0;
      gen_dv         <= 1'b0;
      gen_cipher_key <= '0;
      gen_key_needed <= 1'b0;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      dir_reg        <= 1'b0;
      gkr_d_reg      <= 1'b0;
      keys_valid     <= 1'b0;
      rk_valid       <= 1'b0;
      rk_round       <= '0;
      blk_done       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      key_in_ready   <= (state_next == S_IDLE) || (state_next == S_READY);
      gen_dv         <= (state_next == S_START);
      gkr_d_reg      <= gen_key_ready;
      gen_key_needed <= cap & ~wr_last;
      rd_idx_reg     <= rd_idx_next;
      rk_valid       <= (state_next == S_SERVE);
      rk_round       <= (state_next == S_SERVE) ? rd_idx_next : '0;
      blk_done       <= rk_acc & rd_last;
      if (key_acc) begin
        gen_cipher_key <= key_in;
        wr_idx_reg     <= '0;
        keys_valid     <= 1'b0;
      end else if (cap) begin
        if (wr_last) keys_valid <= 1'b1;
        else         wr_idx_reg <= wr_idx_reg + ONE_IDX;
      end
      if (blk_acc) dir_reg <= blk_dir;
    end
  end

  // Store write port: one round key per capture edge.
  always_ff @(posedge clk) begin
    if (cap) store[wr_idx_reg] <= gen_rkey;
  end

  // Store read port: registered, follows the index the next cycle will present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_data <= '0;
    end else if (state_next == S_SERVE) begin
      rk_data <= store[rd_idx_next];
    end
  end

endmodule
